// File: rtl/bf16_mm_pkg.sv
// bf16_mm_pkg: shared types and constants for the bfloat16 matrix datapath.
//   bf16_t          raw bfloat16 element
//   loader_state_t  bf16_matrix_loader control states
//   BF16_ONE/ZERO   handy bfloat16 constants
package bf16_mm_pkg;

  typedef logic [15:0] bf16_t;

  typedef enum logic [1:0] {
    LOAD_A,
    LOAD_B,
    START,
    WAIT
  } loader_state_t;

  localparam bf16_t BF16_ONE  = 16'h3F80;
  localparam bf16_t BF16_ZERO = 16'h0000;

endpackage

// File: rtl/bf16_finish_tracker.sv
// bf16_finish_tracker: sticky collector of per-output finish flags.
//   clk, rst_n   clock, synchronous active-low reset
//   clear_i      wipe the collected flags (start of a new operation)
//   en_i         collect fin_i this cycle (ignored when low)
//   fin_i        per-output finish bits, pulse or level
//   all_done_o   every bit seen, counting this cycle's fin_i
module bf16_finish_tracker #(
  parameter int NUM = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clear_i,
  input  logic           en_i,
  input  logic [NUM-1:0] fin_i,
  output logic           all_done_o
);

  logic [NUM-1:0] fin_seen_q, fin_seen_d;

  always_comb begin
    fin_seen_d = fin_seen_q;
    if (clear_i)   fin_seen_d = '0;
    else if (en_i) fin_seen_d = fin_seen_q | fin_i;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) fin_seen_q <= '0;
    else        fin_seen_q <= fin_seen_d;
  end

  // Look through to the next value so a finish arriving this cycle counts now.
  assign all_done_o = en_i & (&fin_seen_d);

endmodule

// File: rtl/bf16_matrix_loader.sv
// bf16_matrix_loader: serial bfloat16 stream -> A/B register arrays for the
// matrix multiplier, then a one-cycle start strobe and a wait for all finishes.
//   clk, rst_n          clock, synchronous active-low reset
//   in_valid/in_ready   element handshake; in_data is the element
//   A, B                SIZE x SIZE operand arrays, held until overwritten
//   OP_START            per-MAC start strobe, high for the single START cycle
//   OP_FINISH           per-output finish, collected only while waiting
//   busy                high in START and WAIT
//   done                one-cycle pulse once every finish bit was collected
// Build option: define BF16_LOADER_TRANSPOSE_EN to store elements column-major
// (stream lands transposed); default is row-major.
module bf16_matrix_loader
  import bf16_mm_pkg::*;
#(
  parameter int N    = 16,
  parameter int SIZE = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  output logic [N-1:0] A [SIZE][SIZE],
  output logic [N-1:0] B [SIZE][SIZE],
  output logic         OP_START [SIZE*SIZE*SIZE],
  input  logic         OP_FINISH [SIZE*SIZE],
  output logic         busy,
  output logic         done
);

  localparam int ELEMS = SIZE * SIZE;
  localparam int MACS  = ELEMS * SIZE;
  localparam int CNT_W = (ELEMS > 1) ? $clog2(ELEMS) : 1;
  localparam int IDX_W = (SIZE > 1) ? $clog2(SIZE) : 1;

  loader_state_t    state_q, state_d;
  logic [CNT_W-1:0] elem_cnt_q, elem_cnt_d;
  logic [N-1:0]     a_q [SIZE][SIZE];
  logic [N-1:0]     b_q [SIZE][SIZE];
  logic             op_start_q, done_q;
  logic             hs, last, all_done;
  logic [IDX_W-1:0] row_idx, col_idx, wr_row, wr_col;
  logic [ELEMS-1:0] fin_vec;

  assign hs   = in_valid & in_ready;
  assign last = (elem_cnt_q == CNT_W'(ELEMS - 1));

  always_comb begin
    row_idx = IDX_W'(elem_cnt_q / CNT_W'(SIZE));
    col_idx = IDX_W'(elem_cnt_q % CNT_W'(SIZE));
`ifdef BF16_LOADER_TRANSPOSE_EN
    wr_row  = col_idx;
    wr_col  = row_idx;
`else
    wr_row  = row_idx;
    wr_col  = col_idx;
`endif
  end

  // ---- FSM: state register ----
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= LOAD_A;
    else        state_q <= state_d;
  end

  // ---- FSM: next state ----
  always_comb begin
    state_d = state_q;
    case (state_q)
      LOAD_A:  if (hs && last) state_d = LOAD_B;
      LOAD_B:  if (hs && last) state_d = START;
      START:   state_d = WAIT;
      WAIT:    if (all_done) state_d = LOAD_A;
      default: state_d = LOAD_A;
    endcase
  end

  // ---- FSM: outputs ----
  always_comb begin
    in_ready = rst_n && (state_q == LOAD_A || state_q == LOAD_B);
    busy     = (state_q == START || state_q == WAIT);
  end

  // Counter wraps explicitly so non-power-of-two SIZE still restarts at 0.
  always_comb begin
    elem_cnt_d = elem_cnt_q;
    if (hs) elem_cnt_d = last ? '0 : elem_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      elem_cnt_q <= '0;
      op_start_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      elem_cnt_q <= elem_cnt_d;
      op_start_q <= (state_q == LOAD_B) && hs && last;
      done_q     <= all_done;
    end
  end

  // Operand storage: never cleared on done, only overwritten by the next load.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int r = 0; r < SIZE; r++)
        for (int c = 0; c < SIZE; c++) begin
          a_q[r][c] <= N'(BF16_ZERO);
          b_q[r][c] <= N'(BF16_ZERO);
        end
    end else if (hs) begin
      if (state_q == LOAD_A) a_q[wr_row][wr_col] <= in_data;
      else                   b_q[wr_row][wr_col] <= in_data;
    end
  end

  for (genvar i = 0; i < ELEMS; i++) begin : g_fin
    assign fin_vec[i] = OP_FINISH[i];
  end

  for (genvar i = 0; i < MACS; i++) begin : g_start
    assign OP_START[i] = op_start_q;
  end

  assign A    = a_q;
  assign B    = b_q;
  assign done = done_q;

  bf16_finish_tracker #(.NUM(ELEMS)) u_fin (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_i   (state_q == START),
    .en_i      (state_q == WAIT),
    .fin_i     (fin_vec),
    .all_done_o(all_done)
  );

endmodule

// File: tb/tb_bf16_matrix_loader.sv
module tb_bf16_matrix_loader;
  import bf16_mm_pkg::*;

  localparam int N     = 16;
  localparam int SIZE  = 4;
  localparam int ELEMS = SIZE * SIZE;
  localparam int MACS  = ELEMS * SIZE;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [N-1:0] in_data = '0;
  logic [N-1:0] A [SIZE][SIZE];
  logic [N-1:0] B [SIZE][SIZE];
  logic         OP_START [MACS];
  logic         OP_FINISH [ELEMS];
  logic         busy, done;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          is_b;
    int          k;
    logic [15:0] data;
  } elem_t;

  elem_t       sb[$];
  logic [15:0] exp_a [SIZE][SIZE];
  logic [15:0] exp_b [SIZE][SIZE];
  bf16_t       row_pat [SIZE] = '{16'h3F80, 16'h4000, 16'h4040, 16'h4080};
  int          fin_order [ELEMS] = '{15, 0, 7, 3, 12, 8, 1, 14, 5, 10, 2, 13, 6, 9, 4, 11};

  bf16_matrix_loader #(.N(N), .SIZE(SIZE)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .A        (A),
    .B        (B),
    .OP_START (OP_START),
    .OP_FINISH(OP_FINISH),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Expected landing spot of stream element k.
  function automatic int loc_r(input int k);
`ifdef BF16_LOADER_TRANSPOSE_EN
    return k % SIZE;
`else
    return k / SIZE;
`endif
  endfunction

  function automatic int loc_c(input int k);
`ifdef BF16_LOADER_TRANSPOSE_EN
    return k / SIZE;
`else
    return k % SIZE;
`endif
  endfunction

  function automatic int op_start_ones();
    int n = 0;
    for (int i = 0; i < MACS; i++) if (OP_START[i] === 1'b1) n++;
    return n;
  endfunction

  function automatic int nonzero_ab();
    int n = 0;
    for (int r = 0; r < SIZE; r++)
      for (int c = 0; c < SIZE; c++) begin
        if (A[r][c] !== 16'h0000) n++;
        if (B[r][c] !== 16'h0000) n++;
      end
    return n;
  endfunction

  task automatic set_finish(input bit all_v, input int one_hot);
    for (int i = 0; i < ELEMS; i++) OP_FINISH[i] = all_v || (i == one_hot);
  endtask

  task automatic zero_model();
    for (int r = 0; r < SIZE; r++)
      for (int c = 0; c < SIZE; c++) begin
        exp_a[r][c] = 16'h0000;
        exp_b[r][c] = 16'h0000;
      end
  endtask

  // Drive n_hs handshakes (A elements first, then B); each accepted element
  // goes onto the scoreboard. Returns just after the last handshake edge.
  task automatic stream(input bit gappy, input int n_hs, input logic [15:0] first_val);
    int sent = 0;
    int cyc = 0;
    bit tog = 1'b0;
    while (sent < n_hs && cyc < 400) begin
      @(negedge clk);
      tog      = ~tog;
      in_valid = gappy ? tog : 1'b1;
      in_data  = in_valid ? ((sent == 0) ? first_val : row_pat[sent % SIZE]) : 16'hBAD0;
      if (in_valid && in_ready) begin
        sb.push_back('{is_b: (sent >= ELEMS), k: sent % ELEMS, data: in_data});
        sent++;
      end
      @(posedge clk);
      cyc++;
    end
    checks++;
    if (sent != n_hs) begin
      errors++;
      $display("FAIL stream_handshakes: got %0d, expected %0d", sent, n_hs);
    end
  endtask

  task automatic check_contents();
    elem_t e;
    int r, c;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      r = loc_r(e.k);
      c = loc_c(e.k);
      checks++;
      if (e.is_b) begin
        exp_b[r][c] = e.data;
        if (B[r][c] !== e.data) begin
          errors++;
          $display("FAIL B[%0d][%0d]: got %h, expected %h", r, c, B[r][c], e.data);
        end
      end else begin
        exp_a[r][c] = e.data;
        if (A[r][c] !== e.data) begin
          errors++;
          $display("FAIL A[%0d][%0d]: got %h, expected %h", r, c, A[r][c], e.data);
        end
      end
    end
  endtask

  task automatic compare_model(input string tag);
    for (int r = 0; r < SIZE; r++)
      for (int c = 0; c < SIZE; c++) begin
        checks++;
        if (A[r][c] !== exp_a[r][c] || B[r][c] !== exp_b[r][c]) begin
          errors++;
          $display("FAIL %s[%0d][%0d]: got A=%h B=%h, expected A=%h B=%h",
                   tag, r, c, A[r][c], B[r][c], exp_a[r][c], exp_b[r][c]);
        end
      end
  endtask

  // At the START-cycle negedge: strobe up, then next cycle strobe down, still busy.
  task automatic check_start_window(input bit junk_valid);
    checks++;
    if (op_start_ones() != MACS || busy !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL start_cycle: op_start ones=%0d busy=%b in_ready=%b, expected %0d 1 0",
               op_start_ones(), busy, in_ready, MACS);
    end
    in_valid = junk_valid;
    in_data  = 16'hDEAD;
    @(posedge clk); @(negedge clk);
    checks++;
    if (op_start_ones() != 0 || busy !== 1'b1 || in_ready !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL wait_entry: op_start ones=%0d busy=%b in_ready=%b done=%b, expected 0 1 0 0",
               op_start_ones(), busy, in_ready, done);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b1;
    set_finish(1'b0, -1);
    zero_model();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || op_start_ones() != 0 || nonzero_ab() != 0) begin
      errors++;
      $display("FAIL reset_state: in_ready=%b busy=%b done=%b op_start=%0d nonzero=%0d, expected all 0",
               in_ready, busy, done, op_start_ones(), nonzero_ab());
    end
    in_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_reset: got %b, expected 1", in_ready);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] a01, a10;
    stream(1'b0, 2 * ELEMS, 16'h3F80);
    @(negedge clk);
`ifdef BF16_LOADER_TRANSPOSE_EN
    a01 = A[1][0]; a10 = A[0][1];
`else
    a01 = A[0][1]; a10 = A[1][0];
`endif
    // a01 is where element 1 must land, a10 the mirrored spot.
    checks++;
    if (a01 !== 16'h4000 || a10 === 16'h4000) begin
      errors++;
      $display("FAIL elem1_placement: got target=%h mirror=%h, expected 4000 and not 4000", a01, a10);
    end
    checks++;
`ifdef BF16_LOADER_TRANSPOSE_EN
    if (A[0][3] !== 16'h3F80 || B[3][0] !== 16'h4080) begin
      errors++;
      $display("FAIL corners: got A03=%h B30=%h, expected 3f80 4080", A[0][3], B[3][0]);
    end
`else
    if (A[0][3] !== 16'h4080 || B[3][0] !== 16'h3F80) begin
      errors++;
      $display("FAIL corners: got A03=%h B30=%h, expected 4080 3f80", A[0][3], B[3][0]);
    end
`endif
    check_start_window(1'b0);
    check_contents();
  endtask

  task automatic test_finish_pulses();
    for (int i = 0; i < ELEMS; i++) begin
      set_finish(1'b0, fin_order[i]);
      checks++;
      if (done !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL early_done pulse %0d: done=%b busy=%b, expected 0 1", i, done, busy);
      end
      @(posedge clk); @(negedge clk);
    end
    set_finish(1'b0, -1);
    checks++;
    if (done !== 1'b1 || in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse: done=%b in_ready=%b busy=%b, expected 1 1 0", done, in_ready, busy);
    end
    @(posedge clk); @(negedge clk);
    checks++;
    if (done !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL done_width: done=%b in_ready=%b, expected 0 1", done, in_ready);
    end
    compare_model("hold_after_done");
  endtask

  task automatic test_gappy_and_ignored_finish();
    set_finish(1'b1, -1);   // must be ignored during load and START
    stream(1'b1, 2 * ELEMS, 16'h3F80);
    @(negedge clk);
    check_start_window(1'b1);
    set_finish(1'b0, -1);
    repeat (3) begin
      @(posedge clk); @(negedge clk);
      checks++;
      if (in_ready !== 1'b0 || done !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL wait_hold: in_ready=%b done=%b busy=%b, expected 0 0 1", in_ready, done, busy);
      end
    end
    in_valid = 1'b0;
    check_contents();
    compare_model("gappy_model");
  endtask

  task automatic test_mid_reset();
    stream(1'b0, 20, 16'h3F80);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || op_start_ones() != 0 || nonzero_ab() != 0) begin
      errors++;
      $display("FAIL mid_reset: in_ready=%b busy=%b done=%b op_start=%0d nonzero=%0d, expected all 0",
               in_ready, busy, done, op_start_ones(), nonzero_ab());
    end
    rst_n = 1'b1;
    sb.delete();
    zero_model();
    stream(1'b0, 2 * ELEMS, 16'h1234);
    @(negedge clk);
    checks++;
    if (A[0][0] !== 16'h1234) begin
      errors++;
      $display("FAIL first_after_reset A[0][0]: got %h, expected 1234", A[0][0]);
    end
    check_start_window(1'b0);
    check_contents();
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_finish_pulses();
    test_gappy_and_ignored_finish();
    test_finish_pulses();
    test_mid_reset();
    test_finish_pulses();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
